// File: rtl/onehot_sequencer.sv
// onehot_sequencer: accepts a multi-hot mask and replays each set bit as a
// one-hot beat plus its binary index, highest bit first, over valid/ready.
module onehot_sequencer #(
  parameter  int W  = 8,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [W-1:0]  in_mask,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_onehot,
  output logic [IW-1:0] out_index,
  output logic          out_last,
  output logic          drop_zero
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] pending, pending_nxt;
  logic         drop_nxt;
  logic         accept, beat;

  // Decode the current beat from registered pending only; upper bits
  // overwrite lower ones so the MSB wins. pending is zero outside EMIT,
  // which keeps onehot/index/last at zero while idle.
  always_comb begin
    out_onehot = '0;
    out_index  = '0;
    for (int i = 0; i < W; i++) begin
      if (pending[i]) begin
        out_onehot    = '0;
        out_onehot[i] = 1'b1;
        out_index     = IW'(i);
      end
    end
    out_last  = (pending != '0) && ((pending & (pending - W'(1))) == '0);
    out_valid = (state == EMIT);
  end

  // Handshake terms. in_ready also opens on the final beat so a new mask
  // can follow the old one without an idle cycle.
  always_comb begin
    in_ready = (state == IDLE) | ((state == EMIT) & out_last & out_ready);
    accept   = in_valid & in_ready;
    beat     = out_valid & out_ready;
  end

  // Next-state logic: load, clear bits beat by beat, chain or retire.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    drop_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_mask == '0) begin
            drop_nxt = 1'b1;
          end else begin
            pending_nxt = in_mask;
            state_nxt   = EMIT;
          end
        end
      end
      EMIT: begin
        if (beat) begin
          if (!out_last) begin
            pending_nxt = pending & ~out_onehot;
          end else if (accept && (in_mask != '0)) begin
            pending_nxt = in_mask;
          end else begin
            state_nxt   = IDLE;
            pending_nxt = '0;
            drop_nxt    = accept;
          end
        end
      end
    endcase
  end

  // State, mask and drop pulse registers; synchronous reset discards any
  // partially emitted mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      drop_zero <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      drop_zero <= drop_nxt;
    end
  end

endmodule
